// File: rtl/slave_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : NM-way round-robin one-hot picker with registered last-winner pointer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
   parameter int NM = 4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic [NM-1:0] i_req,
   output logic [NM-1:0] o_pick
);

   localparam int LGNM = (NM > 1) ? $clog2(NM) : 1;

   logic [LGNM-1:0] last_q;
   logic [LGNM-1:0] last_d;
   logic [LGNM-1:0] idx;
   logic            found;

   // Search begins one past the previous winner so every requester gets a turn.
   always_comb begin
      o_pick = '0;
      found  = 1'b0;
      last_d = last_q;
      idx    = '0;
      for (int k = 1; k <= NM; k++) begin
         idx = LGNM'((int'(last_q) + k) % NM);
         if (!found && i_req[idx]) begin
            found       = 1'b1;
            o_pick[idx] = 1'b1;
            last_d      = idx;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         last_q <= LGNM'(NM - 1);
      end else if (found) begin
         last_q <= last_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/slave_arbiter.sv
// ---------------------------------------------------------------------------
// slave_arbiter : per-slave round-robin grant with per-master outstanding-beat hold
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module slave_arbiter #(
   parameter int NM         = 4,
   parameter int NS         = 8,
   parameter int LGMAXBURST = 6
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [NM*(NS+1)-1:0] i_request,
   input  logic [NM-1:0]        i_accept,
   input  logic [NM-1:0]        i_return,
   output logic [NM*(NS+1)-1:0] o_grant,
   output logic [NM-1:0]        o_stall
);

   localparam logic [LGMAXBURST-1:0] CNT_MAX = '1;

   logic [NS:0]   req       [NM];
   logic [NS:0]   grant_all [NM];
   logic [NS-1:0] won       [NM];
   logic [NM-1:0] idle;
   logic [NM-1:0] held      [NS];
   logic [NM-1:0] elig      [NS];
   logic [NM-1:0] pick      [NS];

   for (genvar gm = 0; gm < NM; gm++) begin : g_master
      logic [NS:0]           grant_q, grant_d;
      logic [LGMAXBURST-1:0] cnt_q, cnt_d;

      assign req[gm]                        = i_request[gm*(NS+1) +: NS+1];
      assign grant_all[gm]                  = grant_q;
      assign o_grant[gm*(NS+1) +: NS+1]     = grant_q;
      assign idle[gm]                       = (grant_q == '0);
      assign o_stall[gm] = (req[gm] != '0) && ((grant_q != req[gm]) || (cnt_q == CNT_MAX));

      // A held grant is only dropped once nothing is in flight and the master has moved on.
      always_comb begin
         grant_d = grant_q;
         if (!idle[gm]) begin
            if ((cnt_q == '0) && !i_accept[gm] && (req[gm] != grant_q)) begin
               grant_d = '0;
            end
         end else if (req[gm][NS]) begin
            grant_d = {1'b1, {NS{1'b0}}};
         end else begin
            grant_d = {1'b0, won[gm]};
         end
      end

      always_comb begin
         cnt_d = cnt_q;
         if (i_accept[gm] && !i_return[gm] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
         end else if (!i_accept[gm] && i_return[gm] && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            grant_q <= '0;
            cnt_q   <= '0;
         end else begin
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
         end
      end
   end

   // A slave is arbitrated only while no registered grant holds it.
   for (genvar gs = 0; gs < NS; gs++) begin : g_slave
      logic free;

      for (genvar gm = 0; gm < NM; gm++) begin : g_col
         assign held[gs][gm] = grant_all[gm][gs];
         assign elig[gs][gm] = req[gm][gs] & idle[gm];
         assign won[gm][gs]  = pick[gs][gm];
      end

      assign free = ~|held[gs];

      rr_pick #(
         .NM(NM)
      ) u_rr_pick (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_req   (elig[gs] & {NM{free}}),
         .o_pick  (pick[gs])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_slave_arbiter.sv
// ---------------------------------------------------------------------------
// tb_slave_arbiter : directed stimulus, behavioural model and per-cycle compare
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_slave_arbiter;

   localparam int NM   = 4;
   localparam int NS   = 2;
   localparam int LG   = 2;
   localparam int W    = NS + 1;
   localparam int CMAX = (1 << LG) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NM*W-1:0] req = '0;
   logic [NM-1:0] acc = '0;
   logic [NM-1:0] ret = '0;
   logic [NM*W-1:0] grant;
   logic [NM-1:0] stall;

   slave_arbiter #(
      .NM(NM), .NS(NS), .LGMAXBURST(LG)
   ) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_request (req),
      .i_accept  (acc),
      .i_return  (ret),
      .o_grant   (grant),
      .o_stall   (stall)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model state: granted slot per master (-1 none), outstanding count, last winner per slave.
   int mg   [NM];
   int cnt  [NM];
   int last [NS];
   bit mvalid = 1'b0;

   typedef struct {
      string name;
      int    kind;
      int    m;
      int    exp;
   } lit_t;
   lit_t litq[$];

   function automatic int slot_of(int m);
      for (int s = 0; s < W; s++) if (req[m*W + s]) return s;
      return -1;
   endfunction

   always @(posedge clk) begin : model
      int  nmg [NM];
      int  ncnt[NM];
      int  nlast[NS];
      int  rs;
      int  c;
      bit  busy;
      bit  found;
      for (int m = 0; m < NM; m++) begin nmg[m] = mg[m]; ncnt[m] = cnt[m]; end
      for (int s = 0; s < NS; s++) nlast[s] = last[s];
      if (rst) begin
         for (int m = 0; m < NM; m++) begin nmg[m] = -1; ncnt[m] = 0; end
         for (int s = 0; s < NS; s++) nlast[s] = NM - 1;
      end else begin
         for (int m = 0; m < NM; m++) begin
            rs = slot_of(m);
            if (mg[m] >= 0) begin
               if (cnt[m] == 0 && !acc[m] && rs != mg[m]) nmg[m] = -1;
            end else if (rs == NS) begin
               nmg[m] = NS;
            end
         end
         for (int s = 0; s < NS; s++) begin
            busy = 1'b0;
            for (int m = 0; m < NM; m++) if (mg[m] == s) busy = 1'b1;
            found = 1'b0;
            if (!busy) begin
               for (int k = 1; k <= NM; k++) begin
                  c = (last[s] + k) % NM;
                  if (!found && mg[c] < 0 && slot_of(c) == s) begin
                     nmg[c] = s; nlast[s] = c; found = 1'b1;
                  end
               end
            end
         end
         for (int m = 0; m < NM; m++) begin
            if (acc[m] && !ret[m] && cnt[m] < CMAX) ncnt[m] = cnt[m] + 1;
            else if (!acc[m] && ret[m] && cnt[m] > 0) ncnt[m] = cnt[m] - 1;
         end
      end
      for (int m = 0; m < NM; m++) begin mg[m] <= nmg[m]; cnt[m] <= ncnt[m]; end
      for (int s = 0; s < NS; s++) last[s] <= nlast[s];
      if (rst) mvalid <= 1'b1;
   end

   always @(negedge clk) begin : cmp
      lit_t          it;
      logic [W-1:0]  gs;
      int            e;
      int            rs;
      int            act;
      bit            es;
      if (mvalid) begin
         for (int m = 0; m < NM; m++) begin
            gs = grant[m*W +: W];
            e  = (mg[m] < 0) ? 0 : (1 << mg[m]);
            total++;
            if (int'(gs) != e) begin
               bad++;
               $display("FAIL grant m%0d @%0t: got %b want %0b", m, $time, gs, e);
            end
            rs = slot_of(m);
            es = (rs >= 0) && ((mg[m] != rs) || (cnt[m] == CMAX));
            total++;
            if (stall[m] !== es) begin
               bad++;
               $display("FAIL stall m%0d @%0t: got %b want %b", m, $time, stall[m], es);
            end
         end
      end
      while (litq.size() > 0) begin
         it  = litq.pop_front();
         gs  = grant[it.m*W +: W];
         act = (it.kind == 0) ? int'(gs) : int'(stall[it.m]);
         total++;
         if (act != it.exp) begin
            bad++;
            $display("FAIL %s m%0d @%0t: got %0d want %0d", it.name, it.m, $time, act, it.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setreq(input int m, input int s);
      for (int k = 0; k < W; k++) req[m*W + k] = (k == s);
   endtask

   task automatic lit_g(input string n, input int m, input int e);
      litq.push_back('{n, 0, m, e});
   endtask

   task automatic lit_s(input string n, input int m, input int e);
      litq.push_back('{n, 1, m, e});
   endtask

   initial begin : stim
      int order [5] = '{0, 1, 2, 3, 0};
      int w;

      // Reset state: no grants, stall high for any request.
      rst = 1'b1; setreq(1, 1);
      tick();
      lit_g("rst_grant", 1, 0); lit_s("rst_stall", 1, 1);
      tick();
      setreq(1, -1); rst = 1'b0;

      // Two masters contend for slave 1; master 0 wins first.
      setreq(0, 1); setreq(2, 1);
      tick();
      lit_g("c030_g0", 0, 3'b010); lit_g("c030_g2", 2, 0);
      lit_s("c030_s2", 2, 1);      lit_s("c030_s0", 0, 0);

      // Three beats in flight, then request moves away; grant held until drained.
      for (int i = 0; i < 3; i++) begin acc[0] = 1'b1; tick(); acc[0] = 1'b0; end
      lit_s("c031_full", 0, 1);
      setreq(0, 0);
      for (int i = 0; i < 3; i++) begin
         ret[0] = 1'b1; tick(); ret[0] = 1'b0;
         lit_g("c031_hold", 0, 3'b010);
      end
      tick();
      lit_g("c031_rel", 0, 0); lit_g("c031_m2wait", 2, 0);
      tick();
      lit_g("c031_m2", 2, 3'b010); lit_g("c031_m0s0", 0, 3'b001);
      setreq(0, -1); setreq(2, -1);
      tick(); tick();
      lit_g("c031_clr0", 0, 0); lit_g("c031_clr2", 2, 0);

      // Counter full, saturating violation, then one return clears the stall.
      setreq(1, 0);
      tick();
      lit_g("c033_g1", 1, 3'b001);
      for (int i = 0; i < 3; i++) begin acc[1] = 1'b1; tick(); acc[1] = 1'b0; end
      lit_s("c033_full", 1, 1);
      acc[1] = 1'b1; tick(); acc[1] = 1'b0;
      lit_s("c033_sat", 1, 1);
      ret[1] = 1'b1; tick(); ret[1] = 1'b0;
      lit_s("c033_ret", 1, 0);
      for (int i = 0; i < 2; i++) begin ret[1] = 1'b1; tick(); ret[1] = 1'b0; end
      setreq(1, -1);
      tick(); tick();
      lit_g("c033_clr", 1, 0);

      // All masters on slave 0 with single-beat transactions: strict rotation.
      rst = 1'b1; tick(); rst = 1'b0;
      for (int m = 0; m < NM; m++) setreq(m, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         w = -1;
         for (int c = 0; c < 12; c++) begin
            for (int m = 0; m < NM; m++) if (grant[m*W] == 1'b1) w = m;
            if (w >= 0) break;
            tick();
         end
         lit_g("c032_order", order[i], 3'b001);
         if (w < 0) w = order[i];
         acc[w] = 1'b1; tick(); acc[w] = 1'b0;
         ret[w] = 1'b1; setreq(w, -1); tick(); ret[w] = 1'b0;
         tick();
         setreq(w, 0);
      end
      for (int m = 0; m < NM; m++) setreq(m, -1);
      tick(); tick();

      // Error slot granted while slave 0 is busy; return at zero is ignored.
      setreq(0, 0);
      tick();
      acc[0] = 1'b1; tick(); acc[0] = 1'b0;
      setreq(3, NS);
      tick();
      lit_g("c034_g3", 3, 3'b100); lit_g("c034_g0", 0, 3'b001);
      ret[3] = 1'b1; tick(); ret[3] = 1'b0;
      acc[3] = 1'b1; tick(); acc[3] = 1'b0;
      ret[3] = 1'b1; tick(); ret[3] = 1'b0;
      setreq(3, -1);
      tick();
      lit_g("c034_rel", 3, 0);

      // Reset with beats outstanding drops everything; a fresh request re-grants.
      acc[0] = 1'b1; tick(); acc[0] = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      lit_g("c035_rst", 0, 0);
      tick();
      lit_g("c035_regrant", 0, 3'b001);
      setreq(0, -1);
      tick(); tick();
      lit_g("c035_cnt0", 0, 0);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
